// File: rtl/pwm_dac.sv
// pwm_dac: multi-mode 1-bit DAC output stage.
//
// Converts signed samples into a single-bit stream using one of three modes:
// edge-aligned PWM, center-aligned PWM or first-order sigma-delta.
// Each sample is offset and saturated into a duty value (0..N, N = 2^COUNT_WIDTH).
// Duty is double-buffered (pending -> active) so it only changes at period
// boundaries.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   en           run enable; when low the counter parks at 0 and outputs are 0
//   mode         00 edge PWM, 01 center PWM, 10 sigma-delta, 11 treated as 00
//   data_in      signed two's-complement sample
//   data_valid   single-cycle strobe qualifying data_in
//   pwm_out      registered bitstream to the board pin
//   period_tick  high while pwm_out carries count 0 of a period
//   sat_flag     high while the active duty came from a saturated sample
module pwm_dac #(
  parameter int DATA_WIDTH  = 12,
  parameter int COUNT_WIDTH = 10,
  parameter int OFFSET      = 512
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [1:0]                   mode,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic                         data_valid,
  output logic                         pwm_out,
  output logic                         period_tick,
  output logic                         sat_flag
);

  // Duty width covers 0..N inclusive.
  localparam int DW = COUNT_WIDTH + 1;
  // Sum width wide enough for both the sample path and a signed copy of N.
  localparam int SW = (DATA_WIDTH + 2 > COUNT_WIDTH + 2) ? DATA_WIDTH + 2 : COUNT_WIDTH + 2;

  localparam logic [DW-1:0]          N_D       = {1'b1, {COUNT_WIDTH{1'b0}}};
  localparam logic [DW-1:0]          HALF      = N_D >> 1;
  localparam logic [COUNT_WIDTH-1:0] CNT_LAST  = '1;
  localparam logic signed [SW-1:0]   N_S       = $signed({{(SW-DW){1'b0}}, N_D});
  localparam logic signed [SW-1:0]   OFFSET_S  = SW'(OFFSET);
  localparam logic [DW-1:0]          RST_DUTY  = (OFFSET > (2 ** COUNT_WIDTH)) ? N_D : DW'(OFFSET);

  typedef enum logic [1:0] {
    MODE_EDGE   = 2'b00,
    MODE_CENTER = 2'b01,
    MODE_SD     = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  logic [COUNT_WIDTH-1:0] r_count;
  logic [COUNT_WIDTH-1:0] r_acc;
  logic [DW-1:0]          r_pend_duty;
  logic                   r_pend_sat;
  logic [DW-1:0]          r_active_duty;
  logic                   r_active_sat;
  mode_e                  r_mode_q;
  logic                   r_pwm;
  logic                   r_tick;
  logic                   r_sat;

  logic signed [SW-1:0]   w_ext;
  logic signed [SW-1:0]   w_sum;
  logic [DW-1:0]          w_duty;
  logic                   w_sat;
  logic                   w_boundary;
  logic [DW-1:0]          w_cnt_ext;
  logic [DW-1:0]          w_lo;
  logic [DW-1:0]          w_start;
  logic [DW-1:0]          w_end;
  logic                   w_edge_bit;
  logic                   w_center_bit;
  logic [DW-1:0]          w_acc_sum;
  logic                   w_pwm_next;

  // Offset and saturate the incoming sample.
  assign w_ext = {{(SW-DATA_WIDTH){data_in[DATA_WIDTH-1]}}, data_in};
  assign w_sum = w_ext + OFFSET_S;

  always_comb begin
    w_duty = w_sum[DW-1:0];
    w_sat  = 1'b0;
    if (w_sum[SW-1]) begin
      w_duty = '0;
      w_sat  = 1'b1;
    end else if (w_sum > N_S) begin
      w_duty = N_D;
      w_sat  = 1'b1;
    end
  end

  assign w_boundary = en && (r_count == CNT_LAST);

  // Edge mode: high for the first d counts.
  assign w_cnt_ext  = {1'b0, r_count};
  assign w_edge_bit = (w_cnt_ext < r_active_duty);

  // Center mode: window [H-lo, H-lo+d) holds exactly d counts; end tops out at N.
  assign w_lo         = r_active_duty >> 1;
  assign w_start      = HALF - w_lo;
  assign w_end        = w_start + r_active_duty;
  assign w_center_bit = (w_cnt_ext >= w_start) && (w_cnt_ext < w_end);

  // Sigma-delta: carry out of acc + d is the output bit; d = N always carries.
  assign w_acc_sum = {1'b0, r_acc} + r_active_duty;

  always_comb begin
    w_pwm_next = w_edge_bit;
    case (r_mode_q)
      MODE_CENTER: w_pwm_next = w_center_bit;
      MODE_SD:     w_pwm_next = w_acc_sum[DW-1];
      default:     w_pwm_next = w_edge_bit;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count       <= '0;
      r_acc         <= '0;
      r_pend_duty   <= RST_DUTY;
      r_pend_sat    <= 1'b0;
      r_active_duty <= RST_DUTY;
      r_active_sat  <= 1'b0;
      r_mode_q      <= MODE_EDGE;
      r_pwm         <= 1'b0;
      r_tick        <= 1'b0;
      r_sat         <= 1'b0;
    end else begin
      // Capture runs regardless of en; the last strobe in a period wins.
      if (data_valid) begin
        r_pend_duty <= w_duty;
        r_pend_sat  <= w_sat;
      end

      if (en) begin
        r_count <= r_count + COUNT_WIDTH'(1);
        r_pwm   <= w_pwm_next;
        r_tick  <= (r_count == '0);
        r_sat   <= r_active_sat;

        if (w_boundary) begin
          r_active_duty <= r_pend_duty;
          r_active_sat  <= r_pend_sat;
          r_mode_q      <= mode_e'(mode);
        end

        // Entering sigma-delta from another mode starts from a cleared acc.
        if (w_boundary && (r_mode_q != MODE_SD)) begin
          r_acc <= '0;
        end else begin
          r_acc <= w_acc_sum[COUNT_WIDTH-1:0];
        end
      end else begin
        r_count <= '0;
        r_acc   <= '0;
        r_pwm   <= 1'b0;
        r_tick  <= 1'b0;
        r_sat   <= 1'b0;
      end
    end
  end

  assign pwm_out     = r_pwm;
  assign period_tick = r_tick;
  assign sat_flag    = r_sat;

endmodule

// File: tb/tb_pwm_dac.sv
// Directed bench for pwm_dac with default parameters (N = 1024, OFFSET = 512).
module tb_pwm_dac;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic [1:0]         mode;
  logic signed [11:0] data_in;
  logic               data_valid;
  logic               pwm_out;
  logic               period_tick;
  logic               sat_flag;

  int n_chk = 0;
  int n_err = 0;

  logic [1023:0] smp;
  int ones, first_one, last_one, n_sat, n_tick;
  int w;

  pwm_dac #(.DATA_WIDTH(12), .COUNT_WIDTH(10), .OFFSET(512)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .mode        (mode),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .pwm_out     (pwm_out),
    .period_tick (period_tick),
    .sat_flag    (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge where period_tick is high; returns cycles waited.
  task automatic next_tick(output int waited);
    int i;
    waited = -1;
    i = 0;
    while (waited < 0 && i < 2100) begin
      @(negedge clk);
      i++;
      if (period_tick) waited = i;
    end
    if (waited < 0) chk("tick_timeout", 0, 1);
  endtask

  // Sample one full period starting at the current (tick) negedge.
  task automatic measure();
    smp = '0;
    ones = 0; first_one = -1; last_one = -1; n_sat = 0; n_tick = 0;
    for (int i = 0; i < 1024; i++) begin
      if (i > 0) @(negedge clk);
      smp[i] = pwm_out;
      if (pwm_out) begin
        ones++;
        if (first_one < 0) first_one = i;
        last_one = i;
      end
      if (sat_flag) n_sat++;
      if (period_tick) n_tick++;
    end
  endtask

  task automatic check_period(input string tag, input int e_ones, input int e_first,
                              input int e_last, input int e_sat);
    measure();
    chk({tag, "_ones"},  ones,      e_ones);
    chk({tag, "_first"}, first_one, e_first);
    chk({tag, "_last"},  last_one,  e_last);
    chk({tag, "_sat"},   n_sat,     e_sat);
    chk({tag, "_ticks"}, n_tick,    1);
  endtask

  task automatic send(input int v);
    data_in    = v[11:0];
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  // Load a sample just after a tick, then check the period after the boundary.
  task automatic apply(input logic [1:0] m, input int v, input string tag, input int e_ones,
                       input int e_first, input int e_last, input int e_sat);
    int wt;
    next_tick(wt);
    mode = m;
    send(v);
    next_tick(wt);
    check_period(tag, e_ones, e_first, e_last, e_sat);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; data_in = '0; data_valid = 1'b0;
    #12;
    chk("rst_pwm",  int'(pwm_out),     0);
    chk("rst_tick", int'(period_tick), 0);
    chk("rst_sat",  int'(sat_flag),    0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); en = 1'b1;
    next_tick(w);
    chk("en_first_tick", w, 1);
    check_period("dflt", 512, 0, 511, 0);

    // Edge-mode offset and saturation
    apply(2'b00, -512, "m512", 0,    -1, -1,   0);
    apply(2'b00, -600, "m600", 0,    -1, -1,   1024);
    apply(2'b00,  512, "p512", 1024,  0, 1023, 0);
    apply(2'b00,  700, "p700", 1024,  0, 1023, 1024);
    apply(2'b00,  400, "p400", 912,   0, 911,  0);

    // Center mode
    apply(2'b01, -412, "c100", 100, 462, 561, 0);
    apply(2'b01, -411, "c101", 101, 462, 562, 0);

    // Sigma-delta
    apply(2'b10, -256, "sd256", 256, 3, 1023, 0);
    chk("sd_pat", int'(smp[7:0]), 136);
    apply(2'b10,  512, "sd1024", 1024, 0, 1023, 0);
    apply(2'b10, -412, "sd100",  100, 10, 1023, 0);

    // Mid-period updates held until the boundary; last valid wins
    apply(2'b00, 0, "base", 512, 0, 511, 0);
    next_tick(w);
    fork
      check_period("hold", 512, 0, 511, 0);
      begin
        repeat (100) @(negedge clk);
        send(100);
        mode = 2'b01;
        repeat (200) @(negedge clk);
        send(200);
      end
    join
    next_tick(w);
    fork
      check_period("last_wins", 712, 156, 867, 0);
      begin
        repeat (1022) @(negedge clk);
        send(-312);
      end
    join
    next_tick(w);
    check_period("deferred", 712, 156, 867, 0);
    next_tick(w);
    check_period("deferred_new", 200, 412, 611, 0);

    // Enable drop mid-period and restart
    next_tick(w);
    repeat (450) @(negedge clk);
    chk("en_pre_pwm", int'(pwm_out), 1);
    en = 1'b0;
    @(negedge clk);
    chk("en_off_pwm",  int'(pwm_out),     0);
    chk("en_off_tick", int'(period_tick), 0);
    repeat (5) @(negedge clk);
    chk("en_off_hold", int'(pwm_out), 0);
    en = 1'b1;
    next_tick(w);
    chk("reen_tick_lat", w, 1);
    check_period("reen", 200, 412, 611, 0);

    // Asynchronous reset mid-period
    next_tick(w);
    repeat (450) @(negedge clk);
    chk("rst_pre_pwm", int'(pwm_out), 1);
    mode = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pwm", int'(pwm_out), 0);
    @(negedge clk); rst_n = 1'b1;
    next_tick(w);
    chk("post_rst_tick_lat", w, 1);
    check_period("post_rst", 512, 0, 511, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pwm_dac.md
Name: pwm_dac

Overview:
Multi-mode 1-bit DAC output stage for the audio/baseband path. It converts signed samples to an output bitstream in one of three modes: edge-aligned PWM, center-aligned PWM, or first-order sigma-delta. Samples are offset, saturated, and double-buffered so the duty value changes only at period boundaries. It drives the board output pin directly.

Parameters:
DATA_WIDTH, 12, width of signed two's-complement data_in
COUNT_WIDTH, 10, period counter width; period N = 2^COUNT_WIDTH cycles
OFFSET, 512, constant added to data_in before saturation; must satisfy 0 <= OFFSET < 2^(DATA_WIDTH-1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  run enable
mode  input  2  00 edge PWM, 01 center PWM, 10 sigma-delta, 11 reserved (treated as 00)
data_in  input  DATA_WIDTH  signed sample
data_valid  input  1  data_in qualifier, single-cycle strobe
pwm_out  output  1  registered bitstream
period_tick  output  1  high for the cycle in which pwm_out carries count 0 of a period
sat_flag  output  1  high while the active duty came from a saturated sample

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n).
- Reset state: count=0, pending_duty=active_duty=clamp(OFFSET), pending_sat=active_sat=0, mode_q=00, acc=0. pwm_out, period_tick and sat_flag all 0. Reset mid-period forces these values immediately, with no wait for a clock edge.
- Conversion: s = sign-extended data_in + OFFSET, computed at DATA_WIDTH+2 bits signed.
  - s<0 gives duty 0 with sat=1.
  - s>N gives duty N with sat=1.
  - Otherwise duty=s with sat=0.
  - Duty registers are COUNT_WIDTH+1 bits (range 0..N).
- Capture: data_valid=1 loads pending_duty/pending_sat at the next edge. Multiple valids within one period: the last one wins. data_valid is accepted whatever the state of en.
- Counter: when en=1, count increments 0..N-1 and wraps. When en=0, count is held at 0, acc is cleared, and pwm_out, period_tick and sat_flag are registered 0.
- Boundary: at an enabled edge where count==N-1, active_duty<=pending_duty, active_sat<=pending_sat, mode_q<=mode. A data_valid on that same edge goes to pending only and takes effect at the following boundary.
- Output generation: pwm_out is registered from (count, active_duty, mode_q), giving one cycle of latency from count to pin. Let d=active_duty.
  - Edge mode: pwm_out<=(count<d).
  - Center mode: H=N/2, lo=d>>1; pwm_out<=(count>=H-lo) && (count<H-lo+d), with the compare done at COUNT_WIDTH+1 bits. This gives exactly d high cycles per period, centered.
  - Sigma-delta mode: {c,acc}<=acc+d at COUNT_WIDTH+1 bits on every enabled edge, and pwm_out<=c. This gives exactly d ones per N cycles from a cleared acc. acc is cleared on any boundary where mode_q is not 10.
- Duty extremes: d=0 gives pwm_out constantly 0 and d=N gives constantly 1, in all modes.
- period_tick<=en && (count==0).
- sat_flag<=en && active_sat.
- en rising: count starts at 0, so the first period_tick occurs one cycle after en is sampled high. The active registers keep their values while en=0.
- Mode changes mid-period are ignored until the boundary.

Test Plan:
1. Reset, en=1, mode=00, no data -> d=512. Each period: period_tick, then pwm_out high for 512 cycles and low for 512. sat_flag=0.
2. Edge-mode saturation -> each result appears from the first period_tick after the boundary following capture:
   - data_in=-512 gives pwm_out constant 0, sat=0.
   - data_in=-600 gives pwm_out constant 0, sat=1.
   - data_in=512 gives pwm_out constant 1, sat=0.
   - data_in=700 gives pwm_out constant 1, sat=1.
3. mode=01, data_in=-412 (d=100) -> pwm_out high exactly for counts 462..561 (100 cycles), i.e. output cycles 463..562 after period_tick at cycle 1. d=101 -> high for counts 462..562.
4. mode=10, data_in=-256 (d=256) -> repeating pwm_out pattern 0,0,0,1; 256 ones per 1024 cycles. d=1024 -> all ones.
5. Mid-period: data_valid with 100, then 200 in the same period, plus a mode change -> no output change until the boundary. Then d=712 (last wins) and the new mode take effect. A valid on the count==N-1 edge is deferred one further period.
6. en drop mid-period -> one cycle later pwm_out=0, period_tick=0, count=0. Re-enable -> fresh period aligned to period_tick. rst_n low mid-period -> outputs 0 asynchronously and d returns to 512.
